// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_pkg
//  Description : Register map, CTRL bit indices, handshake states and the
//                byte-lane merge helper shared by the bus timer device.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_timer_pkg;

    localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
    localparam logic [31:0] REG_PRESCALE = 32'h0000_0004;
    localparam logic [31:0] REG_COUNT    = 32'h0000_0008;
    localparam logic [31:0] REG_COMPARE  = 32'h0000_000C;
    localparam logic [31:0] REG_STATUS   = 32'h0000_0010;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_W           = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } dev_state_t;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] data,
                                               input logic [3:0]  mask);
        logic [31:0] v_merged;
        for (int i = 0; i < 4; i++) begin
            v_merged[8*i +: 8] = mask[i] ? data[8*i +: 8] : old_val[8*i +: 8];
        end
        return v_merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_device_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_device_if
//  Description : Generic device-side bus responder: window decode, two-cycle
//                IDLE/RESP handshake, write/read strobes and registered rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_device_if #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WINDOW_LOG2 = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            address,
    input  logic                   ren,
    input  logic                   wen,
    input  logic [31:0]            rdata,
    output logic                   wr_stb,
    output logic                   rd_stb,
    output logic [WINDOW_LOG2-1:0] offset,
    output logic                   active,
    output logic                   ready,
    output logic [31:0]            data_read
);
    import bus_timer_pkg::*;

    dev_state_t  r_state;
    dev_state_t  w_state_next;
    logic [31:0] r_data_read;
    logic [31:0] w_data_read_next;
    logic        w_unused_addr;

    assign active        = (address[31:WINDOW_LOG2] == BASE_ADDR[31:WINDOW_LOG2]);
    assign offset        = {address[WINDOW_LOG2-1:2], 2'b00};
    assign w_unused_addr = ^address[1:0];

    // A request still present during RESP is the one already served, so only
    // IDLE can accept; leaving RESP always returns data_read to zero.
    always_comb begin
        w_state_next     = r_state;
        w_data_read_next = '0;
        wr_stb           = 1'b0;
        rd_stb           = 1'b0;
        case (r_state)
            IDLE: begin
                if ((ren | wen) & active) begin
                    w_state_next = RESP;
                    wr_stb       = wen;
                    rd_stb       = ren & ~wen;
                    if (ren & ~wen) begin
                        w_data_read_next = rdata;
                    end
                end
            end
            RESP: begin
                w_state_next     = IDLE;
            end
            default: begin
                w_state_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data_read <= '0;
        end else begin
            r_state     <= w_state_next;
            r_data_read <= w_data_read_next;
        end
    end

    assign ready     = (r_state == RESP);
    assign data_read = r_data_read;

endmodule
`default_nettype wire

// File: rtl/bus_timer_device.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_device
//  Description : Memory-mapped prescaled 32-bit timer with compare, sticky
//                match flag and level interrupt, behind bus_device_if.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timer_device #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WINDOW_LOG2 = 5,
    parameter int          PRESCALE_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    input  logic [3:0]  write_mask,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] data_read,
    output logic        ready,
    output logic        active,
    output logic        irq
);
    import bus_timer_pkg::*;

    logic                   w_wr_stb;
    logic                   w_rd_stb;
    logic [WINDOW_LOG2-1:0] w_offset;
    logic [31:0]            w_off;
    logic [31:0]            w_rdata;
    logic [31:0]            w_merged;
    logic                   w_unused;

    logic [CTRL_W-1:0]      r_ctrl;
    logic [PRESCALE_W-1:0]  r_prescale;
    logic [PRESCALE_W-1:0]  r_pc;
    logic [31:0]            r_count;
    logic [31:0]            r_compare;
    logic                   r_match;
    logic                   r_irq;

    logic w_wr_ctrl, w_wr_prescale, w_wr_count, w_wr_compare, w_wr_status;
    logic w_tick, w_hit, w_match_clr, w_enable_rise;

    bus_device_if #(
        .BASE_ADDR   (BASE_ADDR),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_bus_if (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .ren       (ren),
        .wen       (wen),
        .rdata     (w_rdata),
        .wr_stb    (w_wr_stb),
        .rd_stb    (w_rd_stb),
        .offset    (w_offset),
        .active    (active),
        .ready     (ready),
        .data_read (data_read)
    );

    assign w_off    = 32'(w_offset);
    assign w_unused = w_rd_stb;

    // Current value of the addressed register; doubles as the merge base for
    // byte-masked writes.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_CTRL:     w_rdata = 32'(r_ctrl);
            REG_PRESCALE: w_rdata = 32'(r_prescale);
            REG_COUNT:    w_rdata = r_count;
            REG_COMPARE:  w_rdata = r_compare;
            REG_STATUS:   w_rdata = {31'b0, r_match};
            default:      w_rdata = '0;
        endcase
    end

    assign w_merged      = apply_mask(w_rdata, data_write, write_mask);
    assign w_wr_ctrl     = w_wr_stb && (w_off == REG_CTRL);
    assign w_wr_prescale = w_wr_stb && (w_off == REG_PRESCALE);
    assign w_wr_count    = w_wr_stb && (w_off == REG_COUNT);
    assign w_wr_compare  = w_wr_stb && (w_off == REG_COMPARE);
    assign w_wr_status   = w_wr_stb && (w_off == REG_STATUS);

    assign w_tick        = r_ctrl[CTRL_ENABLE] && (r_pc == r_prescale);
    assign w_hit         = w_tick && (r_count == r_compare);
    assign w_match_clr   = w_wr_status && write_mask[0] && data_write[0];
    assign w_enable_rise = w_wr_ctrl && w_merged[CTRL_ENABLE] && !r_ctrl[CTRL_ENABLE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pc       <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl)     r_ctrl     <= w_merged[CTRL_W-1:0];
            if (w_wr_prescale) r_prescale <= w_merged[PRESCALE_W-1:0];
            if (w_wr_compare)  r_compare  <= w_merged;

            // A bus write to COUNT beats the increment; the compare above
            // still sees the pre-write value.
            if (w_wr_count) begin
                r_count <= w_merged;
            end else if (w_tick) begin
                r_count <= (w_hit && r_ctrl[CTRL_AUTO_RELOAD]) ? '0 : r_count + 32'd1;
            end

            // pc above a freshly lowered PRESCALE is cleared without a tick.
            if (w_enable_rise) begin
                r_pc <= '0;
            end else if (r_ctrl[CTRL_ENABLE]) begin
                r_pc <= (r_pc >= r_prescale) ? '0 : r_pc + PRESCALE_W'(1);
            end

            r_match <= w_hit | (r_match & ~w_match_clr);
            r_irq   <= r_match & r_ctrl[CTRL_IRQ_EN];
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer_device.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_timer_device
//  Description : Self-checking bench for bus_timer_device: vector table,
//                timed corner sequences and randomized traffic vs. a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer_device;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_write = '0;
    logic [3:0]  write_mask = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] data_read;
    logic        ready;
    logic        active;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bus_timer_device dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_write (data_write),
        .write_mask (write_mask),
        .ren        (ren),
        .wen        (wen),
        .data_read  (data_read),
        .ready      (ready),
        .active     (active),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] prescale;
        logic [15:0] pc;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] rdata;
        logic        match;
        logic        irq;
        logic        resp;
    } mst_t;

    mst_t m;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] k);
        logic [31:0] v;
        v = o;
        for (int i = 0; i < 4; i++) if (k[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    function automatic logic [31:0] regval(input mst_t s, input logic [2:0] off);
        case (off)
            3'd0:    return {29'b0, s.ctrl};
            3'd1:    return {16'b0, s.prescale};
            3'd2:    return s.count;
            3'd3:    return s.compare;
            3'd4:    return {31'b0, s.match};
            default: return 32'h0;
        endcase
    endfunction

    function automatic mst_t mnext(input mst_t s, input logic rstn, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] k,
                                   input logic r, input logic w);
        mst_t        n;
        logic        acc, tick, hit;
        logic [2:0]  off;
        logic [31:0] mv;
        if (!rstn) return '0;
        n    = s;
        off  = a[4:2];
        acc  = !s.resp && (r || w) && (a[31:5] == BASE[31:5]);
        tick = s.ctrl[0] && (s.pc == s.prescale);
        hit  = tick && (s.count == s.compare);
        n.resp  = acc;
        n.rdata = (acc && r && !w) ? regval(s, off) : 32'h0;
        if (s.ctrl[0]) n.pc = (s.pc >= s.prescale) ? 16'h0 : s.pc + 16'd1;
        if (tick) n.count = (hit && s.ctrl[1]) ? 32'h0 : s.count + 32'd1;
        n.irq = s.match & s.ctrl[2];
        if (hit) n.match = 1'b1;
        if (acc && w) begin
            mv = bmerge(regval(s, off), d, k);
            case (off)
                3'd0: begin
                    if (mv[0] && !s.ctrl[0]) n.pc = 16'h0;
                    n.ctrl = mv[2:0];
                end
                3'd1: n.prescale = mv[15:0];
                3'd2: n.count    = mv;
                3'd3: n.compare  = mv;
                3'd4: if (k[0] && d[0] && !hit) n.match = 1'b0;
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) m <= mnext(m, rst_n, address, data_write, write_mask, ren, wen);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", {31'b0, ready}, {31'b0, m.resp});
            check("model_data_read", data_read, m.rdata);
            check("model_irq", {31'b0, irq}, {31'b0, m.irq});
            check("model_active", {31'b0, active}, {31'b0, (address[31:5] == BASE[31:5])});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] k);
        ren = r; wen = w; address = a; data_write = d; write_mask = k;
    endtask

    task automatic idle();
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic wait_to(input int t);
        repeat (t - cyc) @(posedge clk);
        #1;
    endtask

    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] k,
                          output bit rdy_pre, output bit rdy, output bit rdy_post,
                          output logic [31:0] rd);
        @(posedge clk); #1;
        drive(r, w, a, d, k);
        @(negedge clk); rdy_pre = ready;
        @(posedge clk); #1;
        idle();
        @(negedge clk); rdy = ready; rd = data_read;
        @(posedge clk); #1;
        @(negedge clk); rdy_post = ready;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit p, q, s;
        logic [31:0] rd;
        access(1'b0, 1'b1, a, d, 4'hF, p, q, s, rd);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        bit          exp_rdy;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[20];

    initial begin
        bit          p, q, s;
        logic [31:0] rd;
        int          e;

        vt[0]  = '{1, 0, BASE + 32'h00, 32'h0,         4'hF, 1, 32'h0};
        vt[1]  = '{1, 0, BASE + 32'h04, 32'h0,         4'hF, 1, 32'h0};
        vt[2]  = '{1, 0, BASE + 32'h08, 32'h0,         4'hF, 1, 32'h0};
        vt[3]  = '{1, 0, BASE + 32'h0C, 32'h0,         4'hF, 1, 32'h0};
        vt[4]  = '{1, 0, BASE + 32'h10, 32'h0,         4'hF, 1, 32'h0};
        vt[5]  = '{0, 1, BASE + 32'h08, 32'h1234_5678, 4'b0101, 1, 32'h0};
        vt[6]  = '{1, 0, BASE + 32'h08, 32'h0,         4'hF, 1, 32'h0034_0078};
        vt[7]  = '{1, 0, BASE + 32'h20, 32'h0,         4'hF, 0, 32'h0};
        vt[8]  = '{0, 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 32'h0};
        vt[9]  = '{0, 1, BASE + 32'h04, 32'hFFFF_ABCD, 4'hF, 1, 32'h0};
        vt[10] = '{1, 0, BASE + 32'h04, 32'h0,         4'hF, 1, 32'h0000_ABCD};
        vt[11] = '{1, 1, BASE + 32'h0C, 32'hCAFE_F00D, 4'hF, 1, 32'h0};
        vt[12] = '{1, 0, BASE + 32'h0C, 32'h0,         4'hF, 1, 32'hCAFE_F00D};
        vt[13] = '{0, 1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 1, 32'h0};
        vt[14] = '{1, 0, BASE + 32'h14, 32'h0,         4'hF, 1, 32'h0};
        vt[15] = '{0, 1, BASE + 32'h00, 32'h0000_0006, 4'b0001, 1, 32'h0};
        vt[16] = '{1, 0, BASE + 32'h00, 32'h0,         4'hF, 1, 32'h0000_0006};
        vt[17] = '{0, 1, BASE + 32'h00, 32'hFFFF_FF01, 4'b1110, 1, 32'h0};
        vt[18] = '{1, 0, BASE + 32'h00, 32'h0,         4'hF, 1, 32'h0000_0006};
        vt[19] = '{1, 0, 32'h0000_0008, 32'h0,         4'hF, 0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // register map, masking, window decode, ready timing
        for (int i = 0; i < 20; i++) begin
            access(vt[i].r, vt[i].w, vt[i].addr, vt[i].data, vt[i].mask, p, q, s, rd);
            check($sformatf("vec%0d_ready_pre", i), {31'b0, p}, 32'h0);
            check($sformatf("vec%0d_ready", i), {31'b0, q}, {31'b0, vt[i].exp_rdy});
            check($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_ready_post", i), {31'b0, s}, 32'h0);
        end

        // prescale 3, compare 5, auto-reload: match on the 24th cycle
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h04, 32'd3);
        wr(BASE + 32'h0C, 32'd5);
        wr(BASE + 32'h08, 32'd0);
        @(posedge clk); #1;
        drive(0, 1, BASE + 32'h00, 32'h7, 4'hF);
        @(posedge clk); #1; idle(); e = cyc;
        wait_to(e + 24);
        drive(1, 0, BASE + 32'h10, 32'h0, 4'hF);
        @(negedge clk); check("t3_irq_pre", {31'b0, irq}, 32'h0);
        @(posedge clk); #1; idle();
        @(negedge clk);
        check("t3_status_match", data_read, 32'h1);
        check("t3_irq", {31'b0, irq}, 32'h1);
        wait_to(e + 26);
        drive(1, 0, BASE + 32'h08, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t3_count_reload", data_read, 32'h0);
        wait_to(e + 30);
        drive(1, 0, BASE + 32'h08, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t3_count_adv", data_read, 32'h1);
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h10, 32'h1);

        // wrap without match, then match at 7
        wr(BASE + 32'h04, 32'd0);
        wr(BASE + 32'h0C, 32'd7);
        wr(BASE + 32'h08, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        drive(0, 1, BASE + 32'h00, 32'h5, 4'hF);
        @(posedge clk); #1; idle(); e = cyc;
        wait_to(e + 2);
        drive(1, 0, BASE + 32'h08, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t4_wrap", data_read, 32'h0);
        wait_to(e + 4);
        drive(1, 0, BASE + 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t4_no_flag_at_wrap", data_read, 32'h0);
        wait_to(e + 10);
        @(negedge clk); check("t4_irq_pre", {31'b0, irq}, 32'h0);
        @(negedge clk); check("t4_irq_at_7", {31'b0, irq}, 32'h1);
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h10, 32'h1);

        // W1C coincident with a new match
        wr(BASE + 32'h08, 32'd0);
        wr(BASE + 32'h0C, 32'd3);
        @(posedge clk); #1;
        drive(0, 1, BASE + 32'h00, 32'h1, 4'hF);
        @(posedge clk); #1; idle(); e = cyc;
        wait_to(e + 3);
        drive(0, 1, BASE + 32'h10, 32'h1, 4'h1);
        wait_to(e + 5);
        drive(1, 0, BASE + 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t5_set_wins", data_read, 32'h1);
        wait_to(e + 7);
        drive(0, 1, BASE + 32'h10, 32'h1, 4'h1);
        wait_to(e + 9);
        drive(1, 0, BASE + 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t5_w1c", data_read, 32'h0);

        // COUNT write coincident with a tick
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h04, 32'd3);
        wr(BASE + 32'h08, 32'd0);
        wr(BASE + 32'h0C, 32'd1);
        @(posedge clk); #1;
        drive(0, 1, BASE + 32'h00, 32'h1, 4'hF);
        @(posedge clk); #1; idle(); e = cyc;
        wait_to(e + 7);
        drive(0, 1, BASE + 32'h08, 32'h0000_0ABC, 4'hF);
        wait_to(e + 9);
        drive(1, 0, BASE + 32'h08, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t5_count_write_wins", data_read, 32'h0000_0ABC);
        wait_to(e + 11);
        drive(1, 0, BASE + 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t5_old_count_compare", data_read, 32'h1);
        wait_to(e + 13);
        drive(1, 0, BASE + 32'h08, 32'h0, 4'hF);
        @(posedge clk); #1; idle();
        @(negedge clk); check("t5_count_next_tick", data_read, 32'h0000_0ABD);

        // reset during RESP of a read, request held through reset
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h08, 32'h55);
        @(posedge clk); #1;
        drive(1, 0, BASE + 32'h08, 32'h0, 4'hF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); check("t6_resp_data", data_read, 32'h55);
        @(negedge clk);
        check("t6_rst_ready", {31'b0, ready}, 32'h0);
        check("t6_rst_data", data_read, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); check("t6_no_ready_release", {31'b0, ready}, 32'h0);
        @(posedge clk); #1; idle();
        @(negedge clk);
        check("t6_reaccept_ready", {31'b0, ready}, 32'h1);
        check("t6_count_cleared", data_read, 32'h0);
        for (int i = 0; i < 5; i++) begin
            access(1'b1, 1'b0, BASE + 32'(i * 4), 32'h0, 4'hF, p, q, s, rd);
            check($sformatf("t6_reg%0d_zero", i), rd, 32'h0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            logic [2:0]  off;
            @(posedge clk); #1;
            off = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'h20;
                1:       a = $urandom;
                default: a = BASE + {27'b0, off, 2'b00};
            endcase
            rst_n      = ($urandom_range(0, 149) != 0);
            ren        = ($urandom_range(0, 2) == 0);
            wen        = ($urandom_range(0, 3) == 0);
            address    = a;
            write_mask = 4'($urandom);
            case (a[4:2])
                3'd0:    data_write = 32'($urandom_range(0, 7));
                3'd1:    data_write = 32'($urandom_range(0, 4));
                3'd2:    data_write = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 8));
                3'd3:    data_write = 32'($urandom_range(0, 8));
                default: data_write = $urandom;
            endcase
        end
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
